// File: rtl/camera_row_capture.sv
// camera_row_capture: oversamples a YUV422 camera bus, captures one selected row's
// luma bytes and streams them out as an Avalon-ST packet through a small FIFO.
module camera_row_capture #(
    parameter int LINE_PIXELS = 640,
    parameter int ROW_W       = 10,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic             cam_pclk,
    input  logic [7:0]       cam_data,
    input  logic             enable,
    input  logic [ROW_W-1:0] row_select,
    output logic [7:0]       st_data,
    output logic             st_valid,
    input  logic             st_ready,
    output logic             st_sop,
    output logic             st_eop,
    output logic             frame_done,
    output logic             overflow,
    output logic             short_line
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(LINE_PIXELS + 1);

    typedef enum logic [1:0] {IDLE, WAIT_ROW, CAPTURE, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       vs_q, hr_q, pc_q;
    logic [7:0]       d1_q, d2_q;
    logic [ROW_W-1:0] row_sel_q, row_cnt_q;
    logic [PW-1:0]    pix_cnt_q;
    logic             byte_idx_q, overflow_q, short_q, frame_done_q;
    logic [AW:0]      wr_q, rd_q;
    logic [9:0]       mem_q [FIFO_DEPTH];

    logic vsync_rise, vsync_fall, href_rise, href_fall, byte_ok;
    logic start, row_inc, cap_start, cap_byte, push, last, short_set;
    logic empty, full, pop, push_ok;

    // [0] first sync stage, [1] synchronised level, [2] previous level for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q <= '0;
            hr_q <= '0;
            pc_q <= '0;
            d1_q <= '0;
            d2_q <= '0;
        end else begin
            vs_q <= {vs_q[1:0], cam_vsync};
            hr_q <= {hr_q[1:0], cam_href};
            pc_q <= {pc_q[1:0], cam_pclk};
            d1_q <= cam_data;
            d2_q <= d1_q;
        end
    end

    assign vsync_rise = vs_q[1] & ~vs_q[2];
    assign vsync_fall = ~vs_q[1] & vs_q[2];
    assign href_rise  = hr_q[1] & ~hr_q[2];
    assign href_fall  = ~hr_q[1] & hr_q[2];
    // a byte coinciding with the href fall still counts, hence the previous level too
    assign byte_ok    = pc_q[1] & ~pc_q[2] & (hr_q[1] | hr_q[2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     state_d = start ? WAIT_ROW : IDLE;
            WAIT_ROW: state_d = vsync_rise ? IDLE : cap_start ? CAPTURE : WAIT_ROW;
            CAPTURE:  state_d = vsync_rise ? IDLE : (last | short_set) ? DONE : CAPTURE;
            default:  state_d = vsync_rise ? IDLE : DONE;
        endcase
    end

    always_comb begin
        start     = (state_q == IDLE) & vsync_fall & enable;
        row_inc   = (state_q == WAIT_ROW) & ~vsync_rise & href_fall;
        cap_start = (state_q == WAIT_ROW) & ~vsync_rise & href_rise & (row_cnt_q == row_sel_q);
        cap_byte  = (state_q == CAPTURE) & ~vsync_rise & byte_ok;
        push      = cap_byte & ~byte_idx_q;
        last      = push & (pix_cnt_q == PW'(LINE_PIXELS - 1));
        short_set = (state_q == CAPTURE) & ~vsync_rise & href_fall & ~last;
    end

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) & (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = ~empty & st_ready;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_sel_q    <= '0;
            row_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            byte_idx_q   <= 1'b0;
            overflow_q   <= 1'b0;
            short_q      <= 1'b0;
            frame_done_q <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
        end else begin
            if (start) row_sel_q <= row_select;
            row_cnt_q    <= start ? '0 : row_inc ? row_cnt_q + ROW_W'(1) : row_cnt_q;
            byte_idx_q   <= cap_start ? 1'b0 : cap_byte ? ~byte_idx_q : byte_idx_q;
            pix_cnt_q    <= cap_start ? '0 : push ? pix_cnt_q + PW'(1) : pix_cnt_q;
            overflow_q   <= start ? 1'b0 : overflow_q | (push & ~push_ok);
            short_q      <= start ? 1'b0 : short_q | short_set;
            frame_done_q <= last;
            wr_q         <= wr_q + (AW+1)'(push_ok);
            rd_q         <= rd_q + (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= {d2_q, pix_cnt_q == '0, last};
    end

    assign st_valid                 = ~empty;
    assign {st_data, st_sop, st_eop} = empty ? 10'd0 : mem_q[rd_q[AW-1:0]];
    assign frame_done               = frame_done_q;
    assign overflow                 = overflow_q;
    assign short_line               = short_q;
endmodule

// File: tb/tb_camera_row_capture.sv
// tb_camera_row_capture: drives whole camera frames and checks the captured row against
// a packet-level model of which luma samples must appear.
module tb_camera_row_capture;
    localparam int L     = 8;
    localparam int DEPTH = 4;

    logic       clk, reset, cam_vsync, cam_href, cam_pclk, enable, st_ready;
    logic [7:0] cam_data;
    logic [9:0] row_select;
    logic [7:0] st_data;
    logic       st_valid, st_sop, st_eop, frame_done, overflow, short_line;

    camera_row_capture #(.LINE_PIXELS(L), .ROW_W(10), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_pclk(cam_pclk), .cam_data(cam_data), .enable(enable), .row_select(row_select),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .st_sop(st_sop),
        .st_eop(st_eop), .frame_done(frame_done), .overflow(overflow), .short_line(short_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         got     = 0;
    int         fd_total = 0;
    logic [9:0] exp_q[$];
    logic       hold_v = 1'b0;
    logic [9:0] hold_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [7:0] y_of(input int r, input int n);
        int v;
        v = 16 + 64 * (r ^ 2) + n;
        return v[7:0];
    endfunction

    function automatic logic [7:0] byte_of(input int r, input int b);
        int v;
        v = 224 + b;
        return (b % 2 == 0) ? y_of(r, b / 2) : v[7:0];
    endfunction

    // the row's Y samples that must come out, given what the camera sends
    task automatic expect_row(input int nb2, input int abort_b, input bit stall, input bit active,
                              output int k);
        int acc;
        k = active ? nb2 / 2 : 0;
        if (abort_b >= 0 && abort_b / 2 < k) k = abort_b / 2;
        if (k > L) k = L;
        acc = (stall && k > DEPTH) ? DEPTH : k;
        for (int n = 0; n < acc; n++) exp_q.push_back({y_of(2, n), n == 0, n == L - 1});
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        tick(4);
        cam_pclk = 1'b1;
        tick(4);
        cam_pclk = 1'b0;
    endtask

    task automatic run_frame(input int nb2, input int abort_b, input int rst_b, input bit en,
                             input bit en_mid);
        cam_vsync  = 1'b1;
        enable     = en;
        row_select = 10'd2;
        tick(6);
        cam_vsync = 1'b0;
        tick(10);
        for (int r = 0; r < 4; r++) begin
            int nb;
            nb = (r == 2) ? nb2 : 16;
            cam_href = 1'b1;
            tick(2);
            for (int b = 0; b < nb; b++) begin
                if (r == 2 && b == abort_b) begin
                    cam_vsync = 1'b1;
                    tick(4);
                    cam_href = 1'b0;
                    tick(8);
                    return;
                end
                if (r == 2 && b == rst_b) begin
                    chk("pre_reset_valid", st_valid, 1);
                    #1 reset = 1'b1;
                    #1;
                    chk("rst_valid", st_valid, 0);
                    chk("rst_head", {st_data, st_sop, st_eop}, 0);
                    chk("rst_flags", {frame_done, overflow, short_line}, 0);
                    tick(3);
                    reset = 1'b0;
                end
                send_byte(byte_of(r, b));
            end
            tick(2);
            cam_href = 1'b0;
            tick(8);
            if (r == 0 && en_mid) enable = 1'b1;
        end
        cam_vsync = 1'b1;
        tick(6);
    endtask

    task automatic run_test(input int nb2, input int abort_b, input int rst_b, input bit stall,
                            input bit en, input bit en_mid);
        int  k, fd0;
        bit  active;
        active = en && rst_b < 0;
        fd0 = fd_total;
        expect_row(nb2, abort_b, stall, active, k);
        st_ready = !stall;
        run_frame(nb2, abort_b, rst_b, en, en_mid);
        if (stall && rst_b < 0) begin
            chk("stall_valid", st_valid, 1);
            chk("stall_head", {st_data, st_sop}, {8'h10, 1'b1});
            chk("stall_ovf", overflow, 1);
        end
        st_ready = 1'b1;
        for (int i = 0; i < 200 && (st_valid || got < exp_q.size()); i++) tick(1);
        chk("drain_count", got, exp_q.size());
        chk("frame_done_count", fd_total - fd0, (active && abort_b < 0 && k == L) ? 1 : 0);
        if (en) begin
            chk("overflow", overflow, (stall && k > DEPTH) ? 1 : 0);
            chk("short_line", short_line, (active && abort_b < 0 && k < L) ? 1 : 0);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (st_valid && st_ready) begin
                if (got < exp_q.size()) chk($sformatf("beat%0d", got), {st_data, st_sop, st_eop}, exp_q[got]);
                else chk("unexpected_beat", {st_data, st_sop, st_eop}, 10'h3ff);
                got++;
            end
            if (st_valid && !st_ready && hold_v) chk("stall_stable", {st_data, st_sop, st_eop}, hold_d);
            hold_v = st_valid && !st_ready;
            hold_d = {st_data, st_sop, st_eop};
            if (frame_done) fd_total++;
        end
    end

    initial begin
        int k;
        reset = 1'b1; cam_vsync = 1'b1; cam_href = 1'b0; cam_pclk = 1'b0; cam_data = 8'h00;
        enable = 1'b0; row_select = 10'd2; st_ready = 1'b1;
        tick(3);
        chk("reset_valid", st_valid, 0);
        chk("reset_flags", {frame_done, overflow, short_line}, 0);
        reset = 1'b0;
        tick(5);
        expect_row(16, -1, 1'b0, 1'b1, k);
        chk("model_len", exp_q.size(), 8);
        chk("model_last", exp_q[7], {8'h17, 1'b0, 1'b1});
        exp_q.delete();
        run_test(16, -1, -1, 1'b0, 1'b1, 1'b0);
        run_test(16, -1, -1, 1'b1, 1'b1, 1'b0);
        run_test(10, -1, -1, 1'b0, 1'b1, 1'b0);
        chk("short_beats", got, 17);
        run_test(16, -1, -1, 1'b0, 1'b0, 1'b1);
        run_test(16, -1, -1, 1'b0, 1'b1, 1'b0);
        run_test(16, 6, -1, 1'b0, 1'b1, 1'b0);
        run_test(16, -1, -1, 1'b0, 1'b1, 1'b0);
        run_test(16, -1, 4, 1'b1, 1'b1, 1'b0);
        run_test(16, -1, -1, 1'b0, 1'b1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/camera_row_capture.md
Name: camera_row_capture

Overview:
- Sits between the camera pins (vsync, href, pclk, data[7:0]) and the line-processing logic inside soc_system.
- Oversamples the camera bus in the system clock domain and captures one selected image row of YUV422 (Y-first) data.
- Extracts the Y (luma) byte of every pixel and streams the row out on an Avalon-ST source with sop/eop through a small FIFO.
- Provides the line-scan input for NXP Cup track detection.

Parameters:
LINE_PIXELS, 640, Y samples per captured row; eop is tagged on sample LINE_PIXELS-1.
ROW_W, 10, width of row_select and the internal row counter.
FIFO_DEPTH, 16, output FIFO entries; must be a power of 2, minimum 4.

Ports:
clk  in  1  system clock; must be >= 4x camera pclk.
reset  in  1  asynchronous, active-high reset.
cam_vsync  in  1  camera vsync, asynchronous; high during vertical blanking.
cam_href  in  1  camera href, asynchronous; high while row bytes are valid.
cam_pclk  in  1  camera pixel clock, asynchronous; sampled as data, never used as a clock.
cam_data  in  8  camera data byte, asynchronous.
enable  in  1  capture enable; sampled at frame start.
row_select  in  ROW_W  row to capture (0 = first href of the frame); latched at frame start.
st_data  out  8  Y sample.
st_valid  out  1  FIFO not empty.
st_ready  in  1  sink ready.
st_sop  out  1  first sample of the row.
st_eop  out  1  last sample of the row.
frame_done  out  1  one-cycle pulse when a full row has been captured.
overflow  out  1  sticky: a sample was dropped because the FIFO was full; cleared at frame start.
short_line  out  1  sticky: href fell before LINE_PIXELS samples; cleared at frame start.

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, all counters 0.
- Synchronisers:
  - Two flops each on vsync, href, pclk and data, with data delayed identically.
  - pclk_rise = sync_pclk & ~prev_pclk; vsync and href edges are detected the same way.
  - An event at the pins reaches the FSM 3 clk later.
- State IDLE:
  - On vsync fall with enable=1: latch row_select, clear row_cnt, overflow and short_line, go WAIT_ROW.
  - With enable=0: stay in IDLE.
- State WAIT_ROW:
  - Each href fall increments row_cnt.
  - On href rise with row_cnt == latched row: clear byte_idx and pix_cnt, go CAPTURE.
  - A row_select beyond the frame height never matches; vsync rise returns to IDLE with no output.
- State CAPTURE:
  - On each pclk_rise with href=1, toggle byte_idx.
  - When byte_idx was 0, the byte is Y: push {data, sop = (pix_cnt==0), eop = (pix_cnt==LINE_PIXELS-1)} and increment pix_cnt.
  - After the eop push: go DONE and pulse frame_done.
  - href fall with pix_cnt < LINE_PIXELS: set short_line, go DONE, no frame_done, no eop emitted.
- State DONE: ignore bytes; on vsync rise go IDLE.
- Abort: vsync rise in WAIT_ROW or CAPTURE goes to IDLE; samples already in the FIFO remain.
- FIFO push/pop:
  - A push is accepted if not full, or if a pop occurs in the same cycle; otherwise the sample is dropped and overflow is set (the sop/eop flag is lost with it).
  - Pop when st_valid & st_ready.
  - st_data, st_sop and st_eop come from the FIFO head, first-word-fall-through.
  - Push-to-st_valid latency is 1 clk.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- st_data is held stable while st_valid=1 and st_ready=0.
- Simultaneous href fall and pclk_rise in the same cycle: the byte is processed first, then the href fall.

Test Plan:
- LINE_PIXELS=8, row_select=2, pclk = 8 clk, st_ready=1; frame of 4 rows × 16 bytes with Y bytes 0x10+n -> exactly 8 beats from row 2: sop on the first, eop on the 8th; frame_done pulses once; overflow=0.
- Same frame, st_ready=0 throughout, FIFO_DEPTH=4 -> st_valid=1 after the first Y; 4 entries held stable; remaining 4 samples dropped; overflow=1. Next vsync fall -> overflow=0.
- Row 2 carries only 10 bytes (5 Y) -> 5 beats, sop on the first, no eop; short_line=1; frame_done stays 0.
- enable=0 at vsync fall, then set to 1 mid-frame -> no output for that frame; the next frame captures normally.
- vsync rise after 3 Y pushed in CAPTURE -> FSM in IDLE; 3 beats drain; no frame_done; the next frame restarts with sop.
- Assert reset mid-CAPTURE with 2 entries in the FIFO -> st_valid=0, all flags 0 immediately (asynchronous); after release, waits for a vsync fall.
